seq_divider_with_overflow: RTL and testbench
============================================

// Module: seq_divider_with_overflow
// PURPOSE
//  Multi-cycle restoring divider; inverse arithmetic path to the n-bit
//  adder/subtractor (one trial subtraction per cycle, same overflow idiom).
//  Accepts dividend/divisor over a valid/ready handshake.
//  Returns quotient, remainder and status over a valid/ready handshake.
//  Sits beside the ALU datapath for DIV/MOD operations.
// PARAMETERS
//  n  4  operand/result width in bits (n >= 2)
// PORTS
//  clk          input   1  single clock, rising edge
//  rst          input   1  asynchronous, active-high reset
//  in_valid     input   1  operands x,y present
//  in_ready     output  1  divider idle, can accept
//  x            input   n  dividend
//  y            input   n  divisor
//  out_valid    output  1  q,r,div_by_zero,over_flow valid
//  out_ready    input   1  consumer takes result
//  q            output  n  quotient
//  r            output  n  remainder
//  div_by_zero  output  1  y was zero
//  over_flow    output  1  quotient not representable (signed build only)
// BEHAVIOUR
//  - Reset (async, rst=1): state IDLE; in_ready=1; out_valid=0;
//    q, r, div_by_zero, over_flow = 0; iteration counter = 0.
//  - FSM IDLE -> BUSY -> DONE -> IDLE.
//  - IDLE: in_ready=1; accept on in_valid&in_ready.
//    y==0 -> DONE at the next edge (1-cycle latency).
//    Otherwise latch operands, clear partial remainder, counter=n-1 -> BUSY.
//  - BUSY: one restoring step per cycle, MSB first:
//    rem = {rem[n-1:0], dividend[bit]}, n+1 bits wide; diff = rem - {1'b0,y}.
//    No borrow -> rem=diff, quotient bit=1; else rem kept, quotient bit=0.
//    After step with counter==0 -> DONE.
//    out_valid rises exactly n cycles after the accept edge.
//  - DONE: out_valid=1; q,r,flags held stable while out_ready=0.
//    out_valid&out_ready -> IDLE at the next edge.
//    in_ready=0 in BUSY and DONE; in_valid is ignored there (no bypass).
//  - Divide by zero: div_by_zero=1, q = all ones, r = x.
//  - Flags are cleared on the accept of the next operation.
//  - Back-to-back: min 1 IDLE cycle between result drain and next accept.
//  - rst mid-BUSY/DONE: operation aborted, result discarded, reset values.
//  - Unsigned build: q = floor(x/y), r = x - q*y, r < y, over_flow tied 0.
// CONFIGURATION
//  - SIGNED_DIV_EN defined: x,y two's complement.
//    |x|,|y| fed to the unsigned core.
//    q negated when sign(x)^sign(y); rounding is truncation toward zero.
//    r takes the sign of x.
//    x = -2^(n-1) with y = -1: over_flow=1, q = x, r = 0; normal latency.
//    Divide by zero: q = all ones (-1), r = x, over_flow=0.
//  - SIGNED_DIV_EN not defined: unsigned only, no sign logic, over_flow=0.
//  - Latency is identical in both builds.
// TESTING (n=4)
//  - Reset: rst pulse mid-cycle -> all outputs 0, in_ready=1 immediately.
//  - Unsigned: x=13, y=4 -> out_valid n=4 cycles after accept; q=3, r=1, flags 0.
//  - Div by zero: x=7, y=0 -> out_valid 1 cycle after accept;
//    q=4'hF, r=7, div_by_zero=1.
//  - Backpressure: x=15, y=15, out_ready=0 for 5 cycles -> q=1, r=0 held;
//    in_ready=0 and a second in_valid is ignored; drain -> IDLE.
//  - Abort: rst asserted 2 cycles into BUSY -> out_valid never rises for that op.
//    Next op x=9, y=2 -> q=4, r=1.
//  - SIGNED_DIV_EN: x=-7, y=2 -> q=4'hD (-3), r=4'hF (-1).
//    x=-8, y=-1 -> over_flow=1, q=4'h8, r=0.

Source files
------------

// File: rtl/seq_divider_with_overflow_if.sv
// Operand/result handshake bundle for seq_divider_with_overflow.
// The master drives operands and out_ready; the slave (divider) returns results.
interface seq_divider_with_overflow_if #(
    parameter int n = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [n-1:0] x;
    logic [n-1:0] y;
    logic         out_valid;
    logic         out_ready;
    logic [n-1:0] q;
    logic [n-1:0] r;
    logic         div_by_zero;
    logic         over_flow;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, q, r, div_by_zero, over_flow
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, q, r, div_by_zero, over_flow
    );
endinterface

// File: rtl/seq_divider_with_overflow.sv
// Multi-cycle restoring divider, one trial subtraction per cycle, MSB first.
// Define SIGNED_DIV_EN for two's-complement operands (truncating division).
module seq_divider_with_overflow #(
    parameter int n = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    seq_divider_with_overflow_if.slave bus
);
    localparam int CW = $clog2(n);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state_reg, state_next;

    logic [n-1:0]  dividend_reg, divisor_reg, rem_reg, quo_reg;
    logic [n-1:0]  q_reg, r_reg;
    logic [CW-1:0] cnt_reg;
    logic          dbz_reg, ovf_reg, ovf_pend_reg, neg_q_reg, neg_r_reg;

    logic [n-1:0]  x_mag, y_mag;
    logic          x_neg, y_neg, ovf_detect;

    logic [n:0]    rem_shift, diff;
    logic          borrow;
    logic [n-1:0]  rem_step, quo_step;
    logic [1:0]    unused_bits;

    // Operand conditioning: magnitudes go to the unsigned core, signs are
    // remembered so the result can be corrected on the final step.
    always_comb begin
`ifdef SIGNED_DIV_EN
        x_neg      = bus.x[n-1];
        y_neg      = bus.y[n-1];
        x_mag      = x_neg ? -bus.x : bus.x;
        y_mag      = y_neg ? -bus.y : bus.y;
        ovf_detect = (bus.x == {1'b1, {(n-1){1'b0}}}) && (bus.y == '1);
`else
        x_neg      = 1'b0;
        y_neg      = 1'b0;
        x_mag      = bus.x;
        y_mag      = bus.y;
        ovf_detect = 1'b0;
`endif
    end

    // One restoring step; the partial remainder is always < divisor, so the
    // kept result fits back into n bits.
    assign rem_shift   = {rem_reg, dividend_reg[n-1]};
    assign diff        = rem_shift - {1'b0, divisor_reg};
    assign borrow      = rem_shift < {1'b0, divisor_reg};
    assign rem_step    = borrow ? rem_shift[n-1:0] : diff[n-1:0];
    assign quo_step    = {quo_reg[n-2:0], ~borrow};
    assign unused_bits = {diff[n], quo_reg[n-1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_reg)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_next = (bus.y == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt_reg == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dividend_reg <= '0;
            divisor_reg  <= '0;
            rem_reg      <= '0;
            quo_reg      <= '0;
            cnt_reg      <= '0;
            q_reg        <= '0;
            r_reg        <= '0;
            dbz_reg      <= 1'b0;
            ovf_reg      <= 1'b0;
            ovf_pend_reg <= 1'b0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        dbz_reg <= 1'b0;
                        ovf_reg <= 1'b0;
                        if (bus.y == '0) begin
                            q_reg   <= '1;
                            r_reg   <= bus.x;
                            dbz_reg <= 1'b1;
                        end else begin
                            dividend_reg <= x_mag;
                            divisor_reg  <= y_mag;
                            rem_reg      <= '0;
                            quo_reg      <= '0;
                            cnt_reg      <= CW'(n - 1);
                            neg_q_reg    <= x_neg ^ y_neg;
                            neg_r_reg    <= x_neg;
                            ovf_pend_reg <= ovf_detect;
                        end
                    end
                end
                BUSY: begin
                    rem_reg      <= rem_step;
                    quo_reg      <= quo_step;
                    dividend_reg <= {dividend_reg[n-2:0], 1'b0};
                    cnt_reg      <= cnt_reg - CW'(1);
                    // Publish on the last step so results change only when out_valid rises.
                    if (cnt_reg == '0) begin
                        q_reg   <= neg_q_reg ? -quo_step : quo_step;
                        r_reg   <= neg_r_reg ? -rem_step : rem_step;
                        ovf_reg <= ovf_pend_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.q           = q_reg;
    assign bus.r           = r_reg;
    assign bus.div_by_zero = dbz_reg;
    assign bus.over_flow   = ovf_reg;
endmodule

// File: tb/tb_seq_divider_with_overflow.sv
// Directed bench for seq_divider_with_overflow (n=4); signed vectors are
// enabled when SIGNED_DIV_EN is defined for the build.
module tb_seq_divider_with_overflow;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   lat;
    logic seen;

    seq_divider_with_overflow_if #(.n(N)) bif();

    seq_divider_with_overflow #(.n(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one operand pair, return edges from the accept edge to out_valid.
    task automatic start_op(input logic [N-1:0] xv, input logic [N-1:0] yv, output int l);
        int w;
        w = 0;
        while (bif.in_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        check("in_ready_before_accept", {31'b0, bif.in_ready}, 32'd1);
        bif.x        = xv;
        bif.y        = yv;
        bif.in_valid = 1'b1;
        tick();
        bif.in_valid = 1'b0;
        l = 0;
        while (bif.out_valid !== 1'b1 && l < 20) begin
            tick();
            l++;
        end
    endtask

    task automatic check_result(input string tag, input logic [N-1:0] xv, input logic [N-1:0] yv,
                                input int l, input int exp_lat,
                                input logic [N-1:0] eq, input logic [N-1:0] er,
                                input logic edbz, input logic eovf);
        $display("txn %s: x=%0h y=%0h lat=%0d q=%0h r=%0h dbz=%0b ovf=%0b",
                 tag, xv, yv, l, bif.q, bif.r, bif.div_by_zero, bif.over_flow);
        check({tag, "_lat"}, l, exp_lat);
        check({tag, "_q"}, {28'b0, bif.q}, {28'b0, eq});
        check({tag, "_r"}, {28'b0, bif.r}, {28'b0, er});
        check({tag, "_dbz"}, {31'b0, bif.div_by_zero}, {31'b0, edbz});
        check({tag, "_ovf"}, {31'b0, bif.over_flow}, {31'b0, eovf});
    endtask

    task automatic drain(input string tag);
        bif.out_ready = 1'b1;
        tick();
        bif.out_ready = 1'b0;
        check({tag, "_drain_out_valid"}, {31'b0, bif.out_valid}, 32'd0);
        check({tag, "_drain_in_ready"}, {31'b0, bif.in_ready}, 32'd1);
    endtask

    task automatic run(input string tag, input logic [N-1:0] xv, input logic [N-1:0] yv,
                       input int exp_lat, input logic [N-1:0] eq, input logic [N-1:0] er,
                       input logic edbz, input logic eovf);
        int l;
        start_op(xv, yv, l);
        check_result(tag, xv, yv, l, exp_lat, eq, er, edbz, eovf);
        drain(tag);
    endtask

    initial begin
        bif.in_valid  = 1'b0;
        bif.x         = '0;
        bif.y         = '0;
        bif.out_ready = 1'b0;
        rst           = 1'b0;

        // Asynchronous reset asserted between clock edges.
        #1 rst = 1'b1;
        #2;
        check("rst_in_ready", {31'b0, bif.in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, bif.out_valid}, 32'd0);
        check("rst_q", {28'b0, bif.q}, 32'd0);
        check("rst_r", {28'b0, bif.r}, 32'd0);
        check("rst_dbz", {31'b0, bif.div_by_zero}, 32'd0);
        check("rst_ovf", {31'b0, bif.over_flow}, 32'd0);
        #9 rst = 1'b0;
        tick();

`ifdef SIGNED_DIV_EN
        run("x13_y4", 4'd13, 4'd4, N, 4'h0, 4'hD, 1'b0, 1'b0);   // -3 / 4
`else
        run("x13_y4", 4'd13, 4'd4, N, 4'd3, 4'd1, 1'b0, 1'b0);
`endif
        run("x7_y0", 4'd7, 4'd0, 0, 4'hF, 4'd7, 1'b1, 1'b0);

        // Backpressure: result held while out_ready is low, new request ignored.
        start_op(4'd15, 4'd15, lat);
        check_result("x15_y15", 4'd15, 4'd15, lat, N, 4'd1, 4'd0, 1'b0, 1'b0);
        bif.x        = 4'd3;
        bif.y        = 4'd1;
        bif.in_valid = 1'b1;
        repeat (5) begin
            check("bp_out_valid", {31'b0, bif.out_valid}, 32'd1);
            check("bp_in_ready", {31'b0, bif.in_ready}, 32'd0);
            check("bp_q", {28'b0, bif.q}, 32'd1);
            check("bp_r", {28'b0, bif.r}, 32'd0);
            tick();
        end
        bif.in_valid = 1'b0;
        drain("bp");
        tick();
        check("bp_ignored_no_result", {31'b0, bif.out_valid}, 32'd0);

        // Abort: reset two cycles into BUSY.
        check("abort_in_ready", {31'b0, bif.in_ready}, 32'd1);
        bif.x        = 4'd14;
        bif.y        = 4'd3;
        bif.in_valid = 1'b1;
        tick();
        bif.in_valid = 1'b0;
        tick();
        tick();
        check("abort_busy_in_ready", {31'b0, bif.in_ready}, 32'd0);
        #3 rst = 1'b1;
        #1;
        check("abort_rst_in_ready", {31'b0, bif.in_ready}, 32'd1);
        check("abort_rst_out_valid", {31'b0, bif.out_valid}, 32'd0);
        check("abort_rst_q", {28'b0, bif.q}, 32'd0);
        tick();
        rst  = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (bif.out_valid === 1'b1) seen = 1'b1;
        end
        check("abort_no_out_valid", {31'b0, seen}, 32'd0);

`ifdef SIGNED_DIV_EN
        run("x9_y2", 4'd9, 4'd2, N, 4'hD, 4'hF, 1'b0, 1'b0);     // -7 / 2
        run("xm7_y2", 4'h9, 4'd2, N, 4'hD, 4'hF, 1'b0, 1'b0);
        run("xm8_ym1", 4'h8, 4'hF, N, 4'h8, 4'h0, 1'b0, 1'b1);
        run("x7_ym2", 4'd7, 4'hE, N, 4'hD, 4'd1, 1'b0, 1'b0);
        run("xm8_y0", 4'h8, 4'd0, 0, 4'hF, 4'h8, 1'b1, 1'b0);
        run("x6_y3", 4'd6, 4'd3, N, 4'd2, 4'd0, 1'b0, 1'b0);
`else
        run("x9_y2", 4'd9, 4'd2, N, 4'd4, 4'd1, 1'b0, 1'b0);
        run("x6_y7", 4'd6, 4'd7, N, 4'd0, 4'd6, 1'b0, 1'b0);
        run("x15_y1", 4'd15, 4'd1, N, 4'd15, 4'd0, 1'b0, 1'b0);
        run("x8_y3", 4'd8, 4'd3, N, 4'd2, 4'd2, 1'b0, 1'b0);
        run("x15_y0", 4'd15, 4'd0, 0, 4'hF, 4'd15, 1'b1, 1'b0);
        run("x14_y5", 4'd14, 4'd5, N, 4'd2, 4'd4, 1'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
